// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {N,V,C,Z} flags from a, b and opcode.
module alu_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  import alu_pkg::*;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           c;
  logic           v;

  // Arithmetic at WIDTH+1 bits: the top bit is carry for ADD and borrow for SUB.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        c      = diff[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        c      = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        c      = a[0];
      end
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
    flags[FLAG_N] = result[WIDTH-1];
  end

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage valid/ready ALU pipeline with full backpressure and a consumed-result counter.
module pipelined_alu #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] op_count
);
  import alu_pkg::*;

  logic             s1_v;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s2_v;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;

  // Ready ripples back from out_ready only; in_valid never feeds in_ready.
  assign s2_adv    = !s2_v || out_ready;
  assign s1_adv    = !s1_v || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_op <= '0;
    end else if (s1_adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= opcode;
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .opcode (s1_op),
    .result (core_result),
    .flags  (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v   <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        result <= core_result;
        flags  <= core_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (s2_v && out_ready) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu: directed vectors, queue-based reference model checked every cycle.
module tb_pipelined_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] a_i;
  logic [3:0] b_i;
  logic [2:0] op_i;
  logic       in_ready, out_valid;
  logic [3:0] result, flags;
  logic [7:0] op_count;
  logic       in_ready2, out_valid2;
  logic [3:0] result2, flags2;
  logic [1:0] op_count2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipelined_alu #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .opcode(op_i), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .op_count(op_count)
  );

  pipelined_alu #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a_i), .b(b_i), .opcode(op_i), .out_valid(out_valid2), .out_ready(out_ready),
    .result(result2), .flags(flags2), .op_count(op_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, flags packed {N,V,C,Z}.
  function automatic logic [7:0] model(input int a, input int b, input int op);
    int r;
    bit c, v, sa, sb, sr;
    c = 0; v = 0;
    sa = (a >= 8); sb = (b >= 8);
    case (op)
      0: begin r = (a + b) % 16; c = (a + b) >= 16; end
      1: begin r = (a - b + 16) % 16; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: begin r = (a * 2) % 16; c = sa; end
      default: begin r = a / 2; c = (a % 2) == 1; end
    endcase
    sr = (r >= 8);
    if (op == 0) v = (sa == sb) && (sr != sa);
    if (op == 1) v = (sa != sb) && (sr != sa);
    model = {r[3:0], sr, v, c, (r == 0)};
  endfunction

  typedef struct {
    logic [3:0] r;
    logic [3:0] f;
    int         acc;
  } txn_t;

  txn_t       q[$];
  logic [3:0] res_log[$];
  logic [3:0] flg_log[$];
  logic [1:0] cnt2_log[$];
  int         cnt = 0;
  int         acc_cnt = 0;
  int         edge_n = 0;
  bit         prev_stall = 0;
  bit         prev_cons = 0;
  logic [3:0] prev_res, prev_flg;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Reset discards everything in flight, so the model forgets it too.
  always @(negedge rst_n) begin
    q.delete();
    cnt = 0;
    prev_stall = 0;
    prev_cons = 0;
  end

  always @(negedge clk) begin
    bit   exp_valid, consume;
    logic [7:0] m;
    if (!rst_n) begin
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_op_count", {24'b0, op_count}, 0);
    end else begin
      if (prev_cons) cnt2_log.push_back(op_count2);
      exp_valid = (q.size() > 0) && (q[0].acc <= edge_n - 1);
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      chk("out_valid2", {31'b0, out_valid2}, {31'b0, exp_valid});
      chk("in_ready", {31'b0, in_ready}, {31'b0, !(q.size() == 2 && !out_ready)});
      chk("op_count", {24'b0, op_count}, cnt % 256);
      chk("op_count2", {30'b0, op_count2}, cnt % 4);
      if (out_valid && exp_valid) begin
        chk("result", {28'b0, result}, {28'b0, q[0].r});
        chk("flags", {28'b0, flags}, {28'b0, q[0].f});
        chk("result2", {28'b0, result2}, {28'b0, q[0].r});
      end
      if (prev_stall) begin
        chk("stall_result", {28'b0, result}, {28'b0, prev_res});
        chk("stall_flags", {28'b0, flags}, {28'b0, prev_flg});
      end
      consume = out_valid && out_ready;
      if (consume) begin
        res_log.push_back(result);
        flg_log.push_back(flags);
        cnt++;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        m = model(int'(a_i), int'(b_i), int'(op_i));
        q.push_back('{r: m[7:4], f: m[3:0], acc: edge_n + 1});
        acc_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      prev_flg   = flags;
      prev_cons  = consume;
    end
  end

  task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic [2:0] op);
    bit done = 0;
    int tries = 0;
    a_i = ta; b_i = tb; op_i = op; in_valid = 1'b1;
    while (!done && tries < 50) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    in_valid = 1'b0;
    chk("send_accepted", {31'b0, done}, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) break;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  bit tog_on = 0;

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_i = '0; b_i = '0; op_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 0);
    chk("reset_result", {28'b0, result}, 0);
    chk("reset_flags", {28'b0, flags}, 0);
    chk("reset_op_count", {24'b0, op_count}, 0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 1);

    // All eight opcodes back-to-back on a=1100, b=0111.
    for (int unsigned i = 0; i < 8; i++) send(4'hC, 4'h7, 3'(i));
    drain();
    chk("p1_count", res_log.size(), 8);
    chk("p1_add", {res_log[0], flg_log[0]}, 8'h32);
    chk("p1_sub", {res_log[1], flg_log[1]}, 8'h54);
    chk("p1_and", {res_log[2], flg_log[2]}, 8'h40);
    chk("p1_or",  {res_log[3], flg_log[3]}, 8'hF8);
    chk("p1_xor", {res_log[4], flg_log[4]}, 8'hB8);
    chk("p1_not", {res_log[5], flg_log[5]}, 8'h30);
    chk("p1_shl", {res_log[6], flg_log[6]}, 8'h8A);
    chk("p1_shr", {res_log[7], flg_log[7]}, 8'h60);
    chk("p1_op_count", {24'b0, op_count}, 8);

    send(4'h7, 4'h1, 3'b000);
    send(4'h5, 4'h5, 3'b001);
    drain();
    chk("ovf_add", {res_log[8], flg_log[8]}, 8'h8C);
    chk("zero_sub", {res_log[9], flg_log[9]}, 8'h01);
    repeat (2) @(posedge clk);
    chk("cnt2_log_size", {31'b0, cnt2_log.size() >= 5}, 1);
    chk("cnt2_seq0", {30'b0, cnt2_log[0]}, 1);
    chk("cnt2_seq1", {30'b0, cnt2_log[1]}, 2);
    chk("cnt2_seq2", {30'b0, cnt2_log[2]}, 3);
    chk("cnt2_seq3", {30'b0, cnt2_log[3]}, 0);
    chk("cnt2_seq4", {30'b0, cnt2_log[4]}, 1);

    // Stall: output blocked for 5 cycles, only two transactions fit.
    #1;
    out_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        send(4'h1, 4'h2, 3'b000);
        send(4'h9, 4'h3, 3'b001);
        send(4'h6, 4'hA, 3'b100);
        send(4'h3, 4'h4, 3'b011);
      end
    join_none
    repeat (5) @(posedge clk);
    chk("stall_accepts", acc_cnt - base, 2);
    #1;
    out_ready = 1'b1;
    wait fork;
    drain();
    chk("stall_total", res_log.size(), 14);
    chk("stall_sub", {res_log[11], flg_log[11]}, 8'h64);

    // Toggling out_ready with continuous input.
    tog_on = 1;
    fork
      while (tog_on) begin
        @(posedge clk);
        #1;
        out_ready = ~out_ready;
      end
    join_none
    for (int unsigned i = 0; i < 8; i++) send(4'(i), 4'(15 - i), 3'(i));
    tog_on = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();
    chk("toggle_total", res_log.size(), 22);
    chk("toggle_op_count", {24'b0, op_count}, 22);

    // Asynchronous reset with both stages full and stalled.
    out_ready = 1'b0;
    send(4'h3, 4'h1, 3'b000);
    send(4'h6, 4'h2, 3'b010);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", {31'b0, out_valid}, 1);
    chk("pre_rst_result", {28'b0, result}, 4);
    chk("pre_rst_in_ready", {31'b0, in_ready}, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 0);
    chk("async_result", {28'b0, result}, 0);
    chk("async_flags", {28'b0, flags}, 0);
    chk("async_op_count", {24'b0, op_count}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(4'hA, 4'h5, 3'b011);
    send(4'h8, 4'h8, 3'b000);
    drain();
    chk("post_rst_total", res_log.size(), 24);
    chk("post_rst_or", {res_log[22], flg_log[22]}, 8'hF8);
    chk("post_rst_add", {res_log[23], flg_log[23]}, 8'h07);
    chk("post_rst_op_count", {24'b0, op_count}, 2);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
